// File: rtl/xcvr_drp_responder.sv
// Behavioural DRP target: a small per-channel register file that answers each
// accepted drp_en with exactly one drp_rdy pulse, LATENCY cycles later.
module xcvr_drp_responder #(
  parameter int                NUM_CH    = 4,
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 16,
  parameter int                MEM_AW    = 4,
  parameter int                LATENCY   = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        drp_sel,
  input  logic              drp_en,
  input  logic              drp_we,
  input  logic [ADDR_W-1:0] drp_addr,
  input  logic [DATA_W-1:0] drp_wdata,
  output logic [DATA_W-1:0] drp_rdata,
  output logic              drp_rdy,
  output logic              busy,
  output logic              protocol_err,
  input  logic              err_clr,
  output logic [15:0]       txn_count
);

  localparam int         DEPTH    = 2 ** MEM_AW;
  localparam int         CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [7:0] BCAST    = 8'hff;
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          sel_q;
  logic                we_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic                accept;
  logic                sel_bad;
  logic                err_set;

  // Upper address bits only alias onto the implemented words.
  generate
    if (ADDR_W > MEM_AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^drp_addr[ADDR_W-1:MEM_AW];
    end
  endgenerate

  assign sel_bad = (drp_sel >= NUM_CH_B) && (drp_sel != BCAST);
  assign err_set = drp_en && ((state != IDLE) || sel_bad);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drp_rdy    = 1'b0;
    drp_rdata  = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (drp_en) begin
          accept     = 1'b1;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP: begin
        drp_rdy    = 1'b1;
        if (!we_q) drp_rdata = rd_word;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Broadcast reads come from channel 0; unknown channels read as zero.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((sel_q == 8'(c)) || ((c == 0) && (sel_q == BCAST))) rd_word = mem[c][addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      protocol_err <= 1'b0;
      txn_count    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int w = 0; w < DEPTH; w++) mem[c][w] <= RESET_VAL;
      end
    end else begin
      if (accept) begin
        sel_q   <= drp_sel;
        we_q    <= drp_we;
        addr_q  <= drp_addr[MEM_AW-1:0];
        wdata_q <= drp_wdata;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Writes land at the end of the response cycle, so an aborted access never commits.
      if (state == RESP) begin
        txn_count <= txn_count + 16'd1;
        if (we_q) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if ((sel_q == BCAST) || (sel_q == 8'(c))) mem[c][addr_q] <= wdata_q;
          end
        end
      end

      if (err_set)      protocol_err <= 1'b1;
      else if (err_clr) protocol_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xcvr_drp_responder.sv
// Scoreboard bench: the default DUT covers register file, errors and reset abort;
// a LATENCY=1 DUT covers back-to-back throughput and txn_count wrap.
module tb_xcvr_drp_responder;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  logic [7:0]  drp_sel = '0;
  logic        drp_en = 1'b0, drp_we = 1'b0, err_clr = 1'b0;
  logic [11:0] drp_addr = '0;
  logic [15:0] drp_wdata = '0;
  logic [15:0] drp_rdata, txn_count;
  logic        drp_rdy, busy, protocol_err;

  logic [7:0]  l1_sel = '0;
  logic        l1_en = 1'b0, l1_we = 1'b0, l1_err_clr = 1'b0;
  logic [11:0] l1_addr = '0;
  logic [15:0] l1_wdata = '0;
  logic [15:0] l1_rdata, l1_txn_count;
  logic        l1_rdy, l1_busy, l1_err;

  xcvr_drp_responder u0 (
    .clk(clk), .reset(reset), .drp_sel(drp_sel), .drp_en(drp_en), .drp_we(drp_we),
    .drp_addr(drp_addr), .drp_wdata(drp_wdata), .drp_rdata(drp_rdata), .drp_rdy(drp_rdy),
    .busy(busy), .protocol_err(protocol_err), .err_clr(err_clr), .txn_count(txn_count)
  );

  xcvr_drp_responder #(.NUM_CH(1), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .drp_sel(l1_sel), .drp_en(l1_en), .drp_we(l1_we),
    .drp_addr(l1_addr), .drp_wdata(l1_wdata), .drp_rdata(l1_rdata), .drp_rdy(l1_rdy),
    .busy(l1_busy), .protocol_err(l1_err), .err_clr(l1_err_clr), .txn_count(l1_txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Scoreboard for the LATENCY=4 DUT.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (q0.size() > 0 && q0[0].due < cyc) begin
      check("rdy0_missing", cyc, q0[0].due);
      void'(q0.pop_front());
    end
    if (drp_rdy) begin
      if (q0.size() == 0) check("rdy0_unexpected", drp_rdy, 1'b0);
      else begin
        e = q0.pop_front();
        check("rdy0_cycle", cyc, e.due);
        check("rdata0", drp_rdata, e.data);
      end
    end else begin
      check("rdata0_idle", drp_rdata, 16'h0);
    end
  end

  // Scoreboard for the LATENCY=1 DUT.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (q1.size() > 0 && q1[0].due < cyc) begin
      check("rdy1_missing", cyc, q1[0].due);
      void'(q1.pop_front());
    end
    if (l1_rdy) begin
      if (q1.size() == 0) check("rdy1_unexpected", l1_rdy, 1'b0);
      else begin
        e = q1.pop_front();
        check("rdy1_cycle", cyc, e.due);
        check("rdata1", l1_rdata, e.data);
      end
    end
  end

  // Drives one drp_en cycle; returns one ns into the following cycle.
  task automatic apply_stimulus(input logic [7:0] sel, input logic we, input logic [11:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                input bit expect_rdy);
    @(posedge clk); #1;
    drp_en = 1'b1; drp_sel = sel; drp_we = we; drp_addr = addr; drp_wdata = wdata;
    if (expect_rdy) q0.push_back('{due: cyc + 4, data: exp_rdata});
    @(posedge clk); #1;
    drp_en = 1'b0; drp_we = 1'b0; drp_sel = 8'h55; drp_addr = 12'hfff; drp_wdata = 16'hdead;
  endtask

  // Full transaction; the next apply_stimulus lands in the cycle after RESP.
  task automatic txn(input logic [7:0] sel, input logic we, input logic [11:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rdata);
    apply_stimulus(sel, we, addr, wdata, exp_rdata, 1'b1);
    repeat (3) @(posedge clk);
  endtask

  task automatic apply1(input logic we, input logic [15:0] wdata, input logic [15:0] exp_rdata);
    @(posedge clk); #1;
    l1_en = 1'b1; l1_we = we; l1_addr = 12'h001; l1_wdata = wdata;
    q1.push_back('{due: cyc + 1, data: exp_rdata});
    @(posedge clk); #1;
    l1_en = 1'b0; l1_we = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    logic [15:0] last_w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_err", protocol_err, 1'b0);
    check("reset_txn", txn_count, 16'h0);
    check("reset_rdy", drp_rdy, 1'b0);

    $display("[TB] read after reset, busy window");
    apply_stimulus(8'd0, 1'b0, 12'd3, 16'h0, 16'h0000, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("busy_window", busy, 1'b1);
    end
    @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("txn_first", txn_count, 16'd1);

    $display("[TB] write, read back, aliasing");
    txn(8'd2, 1'b1, 12'd5, 16'hA5C3, 16'h0);
    txn(8'd2, 1'b0, 12'd5, 16'h0, 16'hA5C3);
    txn(8'd1, 1'b0, 12'd5, 16'h0, 16'h0000);
    txn(8'd2, 1'b0, 12'h015, 16'h0, 16'hA5C3);

    $display("[TB] broadcast");
    txn(8'hff, 1'b1, 12'd7, 16'h1234, 16'h0);
    for (int c = 0; c < 4; c++) txn(8'(c), 1'b0, 12'd7, 16'h0, 16'h1234);
    txn(8'hff, 1'b0, 12'd7, 16'h0, 16'h1234);
    repeat (2) @(negedge clk);
    check("bcast_no_err", protocol_err, 1'b0);
    check("txn_count_mid", txn_count, 16'd11);

    $display("[TB] strobe while busy");
    apply_stimulus(8'd0, 1'b0, 12'd3, 16'h0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    drp_en = 1'b1; drp_we = 1'b1; drp_sel = 8'd1; drp_addr = 12'd3; drp_wdata = 16'hFFFF;
    @(posedge clk); #1;
    drp_en = 1'b0; drp_we = 1'b0;
    repeat (3) @(negedge clk);
    check("err_busy_strobe", protocol_err, 1'b1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", protocol_err, 1'b0);
    txn(8'd1, 1'b0, 12'd3, 16'h0, 16'h0000);

    $display("[TB] err_clr coinciding with new error");
    apply_stimulus(8'd3, 1'b0, 12'd7, 16'h0, 16'h1234, 1'b1);
    drp_en = 1'b1; err_clr = 1'b1; drp_sel = 8'd0;
    @(posedge clk); #1;
    drp_en = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_collision", protocol_err, 1'b1);
    repeat (3) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;

    $display("[TB] out-of-range select");
    txn(8'd6, 1'b0, 12'd7, 16'h0, 16'h0000);
    repeat (2) @(negedge clk);
    check("err_bad_sel", protocol_err, 1'b1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;

    $display("[TB] reset mid-transaction");
    apply_stimulus(8'd0, 1'b1, 12'd2, 16'hBEEF, 16'h0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_txn", txn_count, 16'd0);
    check("abort_err", protocol_err, 1'b0);
    repeat (4) @(negedge clk);
    txn(8'd0, 1'b0, 12'd2, 16'h0, 16'h0000);
    repeat (2) @(negedge clk);
    check("abort_txn_after", txn_count, 16'd1);
    txn(8'd2, 1'b0, 12'd5, 16'h0, 16'h0000);

    $display("[TB] LATENCY=1 back-to-back and txn_count wrap");
    last_w = 16'h0;
    for (int i = 0; i < 65535; i++) begin
      if (i[0] == 1'b0) begin
        last_w = 16'(i) ^ 16'h5A5A;
        apply1(1'b1, last_w, 16'h0);
      end else begin
        apply1(1'b0, 16'h0, last_w);
      end
    end
    repeat (2) @(negedge clk);
    check("wrap_pre", l1_txn_count, 16'hFFFF);
    apply1(1'b0, 16'h0, last_w);
    repeat (2) @(negedge clk);
    check("wrap_zero", l1_txn_count, 16'h0000);
    check("l1_no_err", l1_err, 1'b0);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
